// File: rtl/sync_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// sync_fifo_wr_arbiter
//
// Round-robin write arbiter sharing one sync_fifo write port between NUM_REQ
// producers. One producer is granted per burst. Its beats pass straight
// through to the FIFO write port, gated by fifo_full. The source index
// travels with each write on fifo_tag.
//
// Optional feature macro: SYNC_FIFO_WR_ARB_STATS_EN
//   When this macro is defined, the block adds per-requester saturating
//   16-bit beat counters (beat_count) and a synchronous clear (stats_clr).
//
// Ports:
//   clock       single clock
//   rst         asynchronous, active-low reset
//   req_valid   per-requester beat valid
//   req_last    per-requester final-beat marker
//   req_data    flattened beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-requester beat accept
//   fifo_full   sync_fifo full flag
//   fifo_wr_en  sync_fifo write enable
//   fifo_din    sync_fifo write data (0 while idle)
//   fifo_tag    source index of the current write (0 while idle)
//   busy        high while a burst is granted (exposes FSM state)
//   stats_clr   (stats build) synchronous clear of beat counters
//   beat_count  (stats build) NUM_REQ x 16-bit beat counters
//
// Handshake: a beat transfers on a rising clock edge where req_valid[i] and
// req_ready[i] are both high. fifo_wr_en is high in exactly that cycle. The
// FIFO accepts the write on the same edge. req_ready never depends on the
// requester's own req_valid.
// ---------------------------------------------------------------------------
module sync_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]      fifo_tag,
  output logic                            busy
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  ,
  input  logic                            stats_clr,
  output logic [NUM_REQ*16-1:0]           beat_count
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [GW-1:0] pick;
  logic          pick_found;
  logic          in_burst;
  logic          g_valid;
  logic          g_last;
  logic          xfer;
  logic [CW-1:0] beat_inc;
  logic          cap_hit;

  // Round-robin search starting one above the previous grant, so the
  // requester that just finished has the lowest priority.
  always_comb begin
    pick       = last_grant_q;
    pick_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_found && req_valid[(int'(last_grant_q) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick       = GW'((int'(last_grant_q) + i) % NUM_REQ);
      end
    end
  end

  assign in_burst = (state_q == ST_BURST);
  assign g_valid  = req_valid[grant_id_q];
  assign g_last   = req_last[grant_id_q];
  assign xfer     = in_burst && g_valid && !fifo_full;
  assign beat_inc = beat_cnt_q + 1'b1;
  assign cap_hit  = (beat_inc == CW'(MAX_BURST));

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d      = ST_BURST;
          grant_id_d   = pick;
          last_grant_d = pick;
          beat_cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_inc;
          if (g_last || cap_hit) state_d = ST_IDLE;
        end else if (!g_valid && !fifo_full) begin
          // Producer stalled while the FIFO could accept: release the port.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Outputs are decoded from registered state, so an asserted reset clears
  // them immediately without waiting for a clock edge.
  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full) req_ready[grant_id_q] = 1'b1;
  end

  assign fifo_wr_en = xfer;
  assign fifo_din   = in_burst ? req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign fifo_tag   = in_burst ? grant_id_q : '0;
  assign busy       = in_burst;

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        stat_q[gi] <= '0;
      end else if (stats_clr) begin
        stat_q[gi] <= '0;
      end else if (xfer && (grant_id_q == GW'(gi)) && (stat_q[gi] != 16'hFFFF)) begin
        stat_q[gi] <= stat_q[gi] + 16'd1;
      end
    end
    assign beat_count[gi*16 +: 16] = stat_q[gi];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
`timescale 1ns/100ps
module tb_sync_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_last;
  logic [NR*DW-1:0]     req_data;
  logic [NR-1:0]        req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_din;
  logic [1:0]           fifo_tag;
  logic                 busy;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic                 stats_clr;
  logic [NR*16-1:0]     beat_count;
`endif

  sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_tag   (fifo_tag),
    .busy       (busy)
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .beat_count (beat_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] pq [NR][$];     // beats each producer still has to send
  bit            pl [NR][$];     // matching last flags
  logic [DW-1:0] exp_q [NR][$];  // expected FIFO contents per source, in order

  int            wr_tag[$];
  int            wr_cyc[$];
  logic [DW-1:0] wr_din[$];
  int            grant_tag[$];
  int            grant_beats[$];
  int            busy_log[$];

  int full_trigger;
  int full_len;
  int full_left;
  int full_busy_cycles;
  int clr_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    for (int s = 0; s < NR; s++) begin
      pq[s].delete(); pl[s].delete(); exp_q[s].delete();
    end
    wr_tag.delete(); wr_cyc.delete(); wr_din.delete();
    grant_tag.delete(); grant_beats.delete(); busy_log.delete();
    full_trigger = -1; full_len = 0; full_left = 0; full_busy_cycles = 0;
    clr_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    clear_logs();
    @(negedge clock);
    rst = 1'b1;
  endtask

  task automatic push_pkt(input int s, input int n, input logic [DW-1:0] base, input bit last_each);
    for (int k = 0; k < n; k++) begin
      pq[s].push_back(base + DW'(k));
      pl[s].push_back(last_each || (k == n - 1));
      exp_q[s].push_back(base + DW'(k));
    end
  endtask

  // Drives all producers from their queues, one cycle per iteration,
  // sampling outputs 1 ns before the active edge.
  task automatic run(input int max_cyc, input bit rand_gap, input bit rand_full);
    int  cyc;
    bit  done;
    bit  all_empty;
    logic prev_busy;
    cyc = 0; done = 1'b0; prev_busy = 1'b0;
    while (!done && cyc < max_cyc) begin
      for (int s = 0; s < NR; s++) begin
        req_valid[s] = (pq[s].size() > 0) && !(rand_gap && $urandom_range(0, 3) == 0);
        req_data[s*DW +: DW] = (pq[s].size() > 0) ? pq[s][0] : '0;
        req_last[s] = (pq[s].size() > 0) ? pl[s][0] : 1'b0;
      end
      fifo_full = (full_left > 0) || (rand_full && $urandom_range(0, 3) == 0);
      if (full_left > 0) full_left--;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
      stats_clr = (cyc == clr_cyc);
`endif
      #4;
      busy_log.push_back(int'(busy));
      if (busy && !prev_busy) begin
        grant_tag.push_back(int'(fifo_tag));
        grant_beats.push_back(0);
      end
      if (fifo_full && busy) full_busy_cycles++;
      chk("ready_blocked_when_full", 64'(req_ready & {NR{fifo_full}}), 64'd0);
      chk("wr_en_vs_handshake", 64'(fifo_wr_en), 64'(|(req_valid & req_ready)));
      if (fifo_wr_en) begin
        chk("no_wr_when_full", 64'(fifo_full), 64'd0);
        wr_tag.push_back(int'(fifo_tag));
        wr_din.push_back(fifo_din);
        wr_cyc.push_back(cyc);
        if (exp_q[fifo_tag].size() == 0) chk("unexpected_write", 64'd1, 64'd0);
        else chk("din_order", fifo_din, exp_q[fifo_tag].pop_front());
        if (grant_beats.size() > 0) begin
          grant_beats[grant_beats.size()-1]++;
          chk("burst_cap", 64'(grant_beats[grant_beats.size()-1] <= MB), 64'd1);
        end
        if (wr_tag.size() == full_trigger) full_left = full_len;
      end
      for (int s = 0; s < NR; s++) begin
        if (req_valid[s] && req_ready[s]) begin
          void'(pq[s].pop_front());
          void'(pl[s].pop_front());
        end
      end
      prev_busy = busy;
      all_empty = 1'b1;
      for (int s = 0; s < NR; s++) if (pq[s].size() > 0) all_empty = 1'b0;
      done = all_empty && !busy;
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end
    chk("run_completed", 64'(done), 64'd1);
    req_valid = '0;
    fifo_full = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int total;
    rst = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    clear_logs();

    // Reset state, with a requester already valid while reset is held.
    #12;
    req_valid = 4'b0001;
    req_data[0 +: DW] = 64'hDEAD;
    #10;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_din", fifo_din, 64'd0);
    chk("rst_tag", 64'(fifo_tag), 64'd0);
    req_valid = '0;

    // Single producer: bubble, then A1..A3 back to back, busy falls after.
    do_reset();
    push_pkt(0, 3, 64'hA1, 1'b0);
    run(50, 1'b0, 1'b0);
    chk("single_nwr", 64'(wr_tag.size()), 64'd3);
    if (wr_tag.size() == 3) begin
      chk("single_d0", wr_din[0], 64'hA1);
      chk("single_d1", wr_din[1], 64'hA2);
      chk("single_d2", wr_din[2], 64'hA3);
      chk("single_c0", 64'(wr_cyc[0]), 64'd1);
      chk("single_c2", 64'(wr_cyc[2]), 64'd3);
      for (int k = 0; k < 3; k++) chk("single_tag", 64'(wr_tag[k]), 64'd0);
    end
    chk("single_busylen", 64'(busy_log.size()), 64'd5);
    if (busy_log.size() == 5) begin
      chk("single_bubble", 64'(busy_log[0]), 64'd0);
      chk("single_busy3", 64'(busy_log[3]), 64'd1);
      chk("single_busy_fall", 64'(busy_log[4]), 64'd0);
    end

    // Fairness: four producers, every beat is last.
    do_reset();
    for (int s = 0; s < NR; s++) push_pkt(s, 2, 64'(s) << 8, 1'b1);
    run(100, 1'b0, 1'b0);
    chk("fair_nwr", 64'(wr_tag.size()), 64'd8);
    if (wr_tag.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("fair_tag", 64'(wr_tag[k]), 64'(k % NR));
        chk("fair_cyc", 64'(wr_cyc[k]), 64'(1 + 2 * k));
      end
    end

    // Burst cap: 10 beats from req2, last only on the tenth.
    do_reset();
    push_pkt(2, 10, 64'h200, 1'b0);
    run(100, 1'b0, 1'b0);
    chk("cap_nwr", 64'(wr_tag.size()), 64'd10);
    chk("cap_grants", 64'(grant_beats.size()), 64'd3);
    if (grant_beats.size() == 3) begin
      chk("cap_g0", 64'(grant_beats[0]), 64'd4);
      chk("cap_g1", 64'(grant_beats[1]), 64'd4);
      chk("cap_g2", 64'(grant_beats[2]), 64'd2);
      for (int k = 0; k < 3; k++) chk("cap_gtag", 64'(grant_tag[k]), 64'd2);
    end
    if (wr_cyc.size() == 10) begin
      chk("cap_c4", 64'(wr_cyc[4]), 64'd6);
      chk("cap_c9", 64'(wr_cyc[9]), 64'd12);
    end

    // Backpressure: 5 full cycles after the second beat of a 4-beat burst.
    do_reset();
    push_pkt(0, 4, 64'h300, 1'b0);
    full_trigger = 2;
    full_len = 5;
    run(100, 1'b0, 1'b0);
    chk("bp_nwr", 64'(wr_tag.size()), 64'd4);
    chk("bp_full_busy", 64'(full_busy_cycles), 64'd5);
    chk("bp_grants", 64'(grant_beats.size()), 64'd1);
    if (wr_cyc.size() == 4) begin
      chk("bp_c1", 64'(wr_cyc[1]), 64'd2);
      chk("bp_c2", 64'(wr_cyc[2]), 64'd8);
      chk("bp_c3", 64'(wr_cyc[3]), 64'd9);
      chk("bp_d2", wr_din[2], 64'h302);
      chk("bp_d3", wr_din[3], 64'h303);
    end

    // Reset mid-burst on req1's second beat.
    do_reset();
    req_valid = 4'b0010; req_last = '0; req_data[1*DW +: DW] = 64'hB0;
    #4;
    chk("rmb_bubble", 64'(fifo_wr_en), 64'd0);
    @(posedge clock); @(negedge clock);
    #4;
    chk("rmb_beat1", fifo_din, 64'hB0);
    @(posedge clock); @(negedge clock);
    req_data[1*DW +: DW] = 64'hB1;
    #4;
    chk("rmb_beat2_wr", 64'(fifo_wr_en), 64'd1);
    chk("rmb_beat2_din", fifo_din, 64'hB1);
    #0.5;
    rst = 1'b0;
    #0.2;
    chk("rmb_async_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rmb_async_busy", 64'(busy), 64'd0);
    chk("rmb_async_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    rst = 1'b1;
    req_valid = '0;
    clear_logs();
    push_pkt(1, 1, 64'hB8, 1'b1);
    push_pkt(0, 1, 64'hB9, 1'b1);
    run(50, 1'b0, 1'b0);
    chk("rmb_nwr", 64'(wr_tag.size()), 64'd2);
    if (wr_tag.size() == 2) begin
      chk("rmb_first", 64'(wr_tag[0]), 64'd0);
      chk("rmb_second", 64'(wr_tag[1]), 64'd1);
    end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    // Beat counters: seven beats from req3, then clear racing a beat.
    do_reset();
    push_pkt(3, 7, 64'h700, 1'b0);
    run(100, 1'b0, 1'b0);
    chk("stats_req3", 64'(beat_count[3*16 +: 16]), 64'd7);
    chk("stats_req0", 64'(beat_count[0 +: 16]), 64'd0);
    push_pkt(3, 1, 64'h7F0, 1'b1);
    clr_cyc = 1;
    run(50, 1'b0, 1'b0);
    chk("stats_clr_wr_cyc", 64'(wr_cyc[wr_cyc.size()-1]), 64'd1);
    chk("stats_clr_wins", 64'(beat_count[3*16 +: 16]), 64'd0);
`endif

    // Random traffic with gaps and backpressure.
    do_reset();
    total = 0;
    for (int s = 0; s < NR; s++) begin
      int npk;
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        int len;
        len = $urandom_range(1, 6);
        push_pkt(s, len, (64'(s) << 56) | (64'($urandom) << 8), 1'b0);
        total += len;
      end
    end
    run(3000, 1'b1, 1'b1);
    chk("rand_total", 64'(wr_tag.size()), 64'(total));
    for (int s = 0; s < NR; s++) chk("rand_drained", 64'(exp_q[s].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
